// File: rtl/usr_pkg.sv
// usr_pkg: shared definitions for the universal shift engine.
//   - 3-bit opcode encodings (HOLD, SHR, SHL, LOAD, ASR, ROR, ROL, CLR)
//   - FSM state encoding (IDLE, SHIFT)
//   - helper that classifies an opcode as a multi-step shift/rotate
package usr_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HOLD = 3'b000;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b001;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b010;
    localparam logic [OP_W-1:0] OP_LOAD = 3'b011;
    localparam logic [OP_W-1:0] OP_ASR  = 3'b100;
    localparam logic [OP_W-1:0] OP_ROR  = 3'b101;
    localparam logic [OP_W-1:0] OP_ROL  = 3'b110;
    localparam logic [OP_W-1:0] OP_CLR  = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Shifts and rotates are stepped one position per cycle; everything
    // else (HOLD, LOAD, CLR) completes at the accept edge.
    function automatic logic is_step_op(input logic [OP_W-1:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ASR) ||
               (op == OP_ROR) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/usr_step_logic.sv
// usr_step_logic: purely combinational single-step datapath.
//   op_i      : opcode selecting the operation
//   q_i       : current register contents
//   msb_in_i  : serial fill for SHR
//   lsb_in_i  : serial fill for SHL
//   load_i    : parallel data for LOAD
//   q_next_o  : register contents after one step
//   out_bit_o : bit shifted/rotated out by this step (0 for non-shift ops)
module usr_step_logic
    import usr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [OP_W-1:0] op_i,
    input  logic [N-1:0]    q_i,
    input  logic            msb_in_i,
    input  logic            lsb_in_i,
    input  logic [N-1:0]    load_i,
    output logic [N-1:0]    q_next_o,
    output logic            out_bit_o
);

    always_comb begin
        q_next_o  = q_i;
        out_bit_o = 1'b0;
        case (op_i)
            OP_SHR: begin
                q_next_o  = {msb_in_i, q_i[N-1:1]};
                out_bit_o = q_i[0];
            end
            OP_SHL: begin
                q_next_o  = {q_i[N-2:0], lsb_in_i};
                out_bit_o = q_i[N-1];
            end
            OP_LOAD: q_next_o = load_i;
            OP_ASR: begin
                q_next_o  = {q_i[N-1], q_i[N-1:1]};
                out_bit_o = q_i[0];
            end
            OP_ROR: begin
                q_next_o  = {q_i[0], q_i[N-1:1]};
                out_bit_o = q_i[0];
            end
            OP_ROL: begin
                q_next_o  = {q_i[N-2:0], q_i[N-1]};
                out_bit_o = q_i[N-1];
            end
            OP_CLR:  q_next_o = '0;
            default: q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/universal_shift_engine.sv
// universal_shift_engine: N-bit universal shift register with multi-step
// shifts/rotates executed one position per cycle and a start/busy/done
// handshake.
//   clk, reset     : clock, synchronous active-high reset
//   start, op, amt : command request (accepted only in IDLE), opcode, step count
//   MSB_in, LSB_in : live serial fills for SHR / SHL
//   I              : parallel load data (used only at a LOAD accept)
//   Q              : register contents
//   shift_out      : last bit shifted or rotated out
//   busy           : high while stepping a shift/rotate
//   done           : one-cycle completion pulse
module universal_shift_engine
    import usr_pkg::*;
#(
    parameter int N     = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [AMT_W-1:0] amt,
    input  logic             MSB_in,
    input  logic             LSB_in,
    input  logic [N-1:0]     I,
    output logic [N-1:0]     Q,
    output logic             shift_out,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     data_q, data_d;
    logic             so_q, so_d;
    logic             done_q, done_d;

    logic [OP_W-1:0]  step_op;
    logic [N-1:0]     step_q;
    logic             step_bit;

    // In SHIFT the latched opcode drives the datapath; in IDLE the incoming
    // opcode does, so single-cycle ops share the same step logic.
    assign step_op = (state_q == ST_SHIFT) ? op_q : op;

    usr_step_logic #(.N(N)) u_step (
        .op_i      (step_op),
        .q_i       (data_q),
        .msb_in_i  (MSB_in),
        .lsb_in_i  (LSB_in),
        .load_i    (I),
        .q_next_o  (step_q),
        .out_bit_o (step_bit)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        so_d    = so_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_step_op(op) && (amt != '0)) begin
                        op_d    = op;
                        cnt_d   = amt;
                        state_d = ST_SHIFT;
                    end else begin
                        // HOLD/LOAD/CLR, or a zero-length shift: Q is only
                        // touched by LOAD/CLR and shift_out is left alone.
                        if (!is_step_op(op)) data_d = step_q;
                        done_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                data_d = step_q;
                so_d   = step_bit;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            data_q  <= '0;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            so_q    <= so_d;
            done_q  <= done_d;
        end
    end

    assign Q         = data_q;
    assign shift_out = so_q;
    assign busy      = (state_q == ST_SHIFT);
    assign done      = done_q;

endmodule

// File: tb/tb_universal_shift_engine.sv
module tb_universal_shift_engine;
    import usr_pkg::*;

    localparam int N     = 8;
    localparam int AMT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic             MSB_in, LSB_in;
    logic [N-1:0]     I;
    logic [N-1:0]     Q;
    logic             shift_out, busy, done;

    int total = 0;
    int bad   = 0;

    universal_shift_engine #(.N(N), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .amt       (amt),
        .MSB_in    (MSB_in),
        .LSB_in    (LSB_in),
        .I         (I),
        .Q         (Q),
        .shift_out (shift_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a command and run until done, counting busy cycles and the
    // start-to-done latency. Only drives stimulus; callers do the checks.
    task automatic do_cmd(input logic [2:0] o, input logic [AMT_W-1:0] a,
                          output int nbusy, output int lat, output bit tmo);
        op = o; amt = a; start = 1'b1;
        tick();
        start = 1'b0;
        nbusy = 0; lat = 1;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
        tmo = !done;
    endtask

    task automatic load(input logic [N-1:0] v);
        int nb, lt; bit tmo;
        I = v;
        do_cmd(OP_LOAD, '0, nb, lt, tmo);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; op = OP_LOAD; I = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || shift_out !== 1'b0) begin
                bad++;
                $display("FAIL reset cyc%0d: Q=%h busy=%b done=%b so=%b want 00/0/0/0",
                         k, Q, busy, done, shift_out);
            end
        end
        reset = 1'b0; start = 1'b0;
    endtask

    task automatic test_load();
        I = 8'hA5; op = OP_LOAD; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (Q !== 8'hA5 || done !== 1'b1 || busy !== 1'b0 || shift_out !== 1'b0) begin
            bad++;
            $display("FAIL load: Q=%h done=%b busy=%b so=%b want a5/1/0/0", Q, done, busy, shift_out);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || Q !== 8'hA5) begin
            bad++;
            $display("FAIL load_after: Q=%h done=%b busy=%b want a5/0/0", Q, done, busy);
        end
    endtask

    task automatic test_shr();
        logic [N-1:0] exp_q [3];
        exp_q[0] = 8'hD2; exp_q[1] = 8'hE9; exp_q[2] = 8'hF4;
        MSB_in = 1'b1; op = OP_SHR; amt = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (Q !== 8'hA5 || busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL shr_accept: Q=%h busy=%b done=%b want a5/1/0", Q, busy, done);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (Q !== exp_q[k] || busy !== (k < 2) || done !== (k == 2)) begin
                bad++;
                $display("FAIL shr_step%0d: Q=%h busy=%b done=%b want %h/%b/%b",
                         k, Q, busy, done, exp_q[k], k < 2, k == 2);
            end
        end
        total++;
        if (shift_out !== 1'b1) begin
            bad++;
            $display("FAIL shr_so: got %b want 1", shift_out);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL shr_done_width: done=%b want 0", done);
        end
    endtask

    task automatic test_asr_rol();
        int nb, lt; bit tmo;
        load(8'h80);
        total++;
        if (Q !== 8'h80 || shift_out !== 1'b1) begin
            bad++;
            $display("FAIL load_keeps_so: Q=%h so=%b want 80/1", Q, shift_out);
        end
        do_cmd(OP_ASR, 4'd7, nb, lt, tmo);
        total++;
        if (tmo || Q !== 8'hFF || shift_out !== 1'b0 || nb != 7 || lt != 8) begin
            bad++;
            $display("FAIL asr7: Q=%h so=%b busy=%0d lat=%0d tmo=%b want ff/0/7/8/0",
                     Q, shift_out, nb, lt, tmo);
        end
        tick();
        load(8'h81);
        do_cmd(OP_ROL, 4'd8, nb, lt, tmo);
        total++;
        if (tmo || Q !== 8'h81 || shift_out !== 1'b1 || nb != 8 || lt != 9) begin
            bad++;
            $display("FAIL rol8: Q=%h so=%b busy=%0d lat=%0d tmo=%b want 81/1/8/9/0",
                     Q, shift_out, nb, lt, tmo);
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int ndone = 0;
        int cyc   = 0;
        load(8'h01);
        LSB_in = 1'b0; op = OP_SHL; amt = 4'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        op = OP_LOAD; I = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        while (!done && cyc < 20) begin tick(); cyc++; end
        if (done) ndone++;
        total++;
        if (Q !== 8'h10 || !done) begin
            bad++;
            $display("FAIL ignored_start: Q=%h done=%b want 10/1", Q, done);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            if (done) ndone++;
        end
        total++;
        if (ndone != 1 || Q !== 8'h10 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignored_start_pulses: dones=%0d Q=%h busy=%b want 1/10/0", ndone, Q, busy);
        end
    endtask

    task automatic test_abort();
        load(8'h3C);
        op = OP_ROR; amt = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total++;
        if (Q !== 8'h1E || busy !== 1'b1) begin
            bad++;
            $display("FAIL ror_step1: Q=%h busy=%b want 1e/1", Q, busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (Q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || shift_out !== 1'b0) begin
            bad++;
            $display("FAIL abort: Q=%h busy=%b done=%b so=%b want 00/0/0/0", Q, busy, done, shift_out);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || Q !== 8'h00) begin
            bad++;
            $display("FAIL abort_after: Q=%h busy=%b done=%b want 00/0/0", Q, busy, done);
        end
    endtask

    task automatic test_zero_amt();
        load(8'h5A);
        op = OP_SHL; amt = '0; LSB_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (Q !== 8'h5A || done !== 1'b1 || busy !== 1'b0 || shift_out !== 1'b0) begin
            bad++;
            $display("FAIL shl0: Q=%h done=%b busy=%b so=%b want 5a/1/0/0", Q, done, busy, shift_out);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL shl0_after: done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    // Saturating SHL beyond N, back-to-back accept while done is high, CLR.
    task automatic test_back_to_back();
        int nb, lt; bit tmo;
        load(8'h00);
        LSB_in = 1'b1;
        do_cmd(OP_SHL, 4'd15, nb, lt, tmo);
        total++;
        if (tmo || Q !== 8'hFF || shift_out !== 1'b1 || nb != 15 || lt != 16) begin
            bad++;
            $display("FAIL shl15: Q=%h so=%b busy=%0d lat=%0d tmo=%b want ff/1/15/16/0",
                     Q, shift_out, nb, lt, tmo);
        end
        // done is high here; a new start must still be accepted.
        MSB_in = 1'b0;
        do_cmd(OP_SHR, 4'd2, nb, lt, tmo);
        total++;
        if (tmo || Q !== 8'h3F || shift_out !== 1'b1 || nb != 2 || lt != 3) begin
            bad++;
            $display("FAIL b2b_shr: Q=%h so=%b busy=%0d lat=%0d tmo=%b want 3f/1/2/3/0",
                     Q, shift_out, nb, lt, tmo);
        end
        do_cmd(OP_CLR, '0, nb, lt, tmo);
        total++;
        if (tmo || Q !== 8'h00 || shift_out !== 1'b1 || nb != 0 || lt != 1) begin
            bad++;
            $display("FAIL clr: Q=%h so=%b busy=%0d lat=%0d tmo=%b want 00/1/0/1/0",
                     Q, shift_out, nb, lt, tmo);
        end
        tick();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = OP_HOLD; amt = '0;
        MSB_in = 1'b0; LSB_in = 1'b0; I = '0;
        #2;
        test_reset();
        test_load();
        test_shr();
        test_asr_rol();
        test_ignored_start();
        test_abort();
        test_zero_amt();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
